// File: rtl/memory_stage.sv
// Pipeline memory stage: decodes lw/sw from the X/M latch, runs them over a req/ack
// data-memory port and emits bubbles while stalled. Optional perf counters: MEM_STAGE_PERF_CNT_EN.
module memory_stage #(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instructionin,
  input  logic [31:0]       aluin,
  input  logic [31:0]       datain,
  input  logic [31:0]       PCin,
  output logic [31:0]       aluout,
  output logic [31:0]       dmemout,
  output logic [31:0]       instructionout,
  output logic [31:0]       PCout,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_err
`ifdef MEM_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       mem_ops
`endif
);

  // Memory handshake: dmem_req stays high with we/addr/wdata stable until the
  // cycle dmem_ack is seen (or the timeout fires); ack is ignored while req is low.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                is_lw, is_sw, is_mem;
  logic                stall_c, pass_c;

  assign is_lw  = (instructionin[31:27] == 5'b01000);
  assign is_sw  = (instructionin[31:27] == 5'b00111);
  assign is_mem = is_lw | is_sw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stall_c = 1'b0;
    pass_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          stall_c = 1'b1;
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = is_sw;
          addr_d  = aluin[ADDR_W-1:0];
          wdata_d = datain;
          cnt_d   = '0;
        end else begin
          pass_c = 1'b1;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (dmem_ack || (cnt_q == TO_LAST)) begin
          rdata_d = (dmem_ack && !we_q) ? dmem_rdata : 32'd0;
          err_d   = err_q | ~dmem_ack;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        pass_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while rst is held, including the registered port.
  always_comb begin
    aluout         = (pass_c && !rst) ? aluin : 32'd0;
    PCout          = (pass_c && !rst) ? PCin : 32'd0;
    instructionout = (pass_c && !rst) ? instructionin : 32'd0;
    dmemout        = (!rst && state_q == RESP && is_lw) ? rdata_q : 32'd0;
    stall          = stall_c & ~rst;
    dmem_req       = req_q & ~rst;
    dmem_we        = we_q & ~rst;
    dmem_addr      = rst ? '0 : addr_q;
    dmem_wdata     = rst ? 32'd0 : wdata_q;
    mem_err        = err_q & ~rst;
  end

`ifdef MEM_STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, ops_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      ops_cnt_q   <= '0;
    end else begin
      if (stall_c && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_q == RESP && ops_cnt_q != 32'hFFFF_FFFF) ops_cnt_q <= ops_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = rst ? 32'd0 : stall_cnt_q;
  assign mem_ops      = rst ? 32'd0 : ops_cnt_q;
`endif

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline memory (M) stage. Sits between the execute-to-memory latch and the memory-to-writeback latch.
- Decodes the instruction held in the X/M latch and runs lw/sw through a variable-latency req/ack data-memory port. Stalls upstream for the duration of the access.
- The M/W latch is always enabled, so this stage drives a bubble (all-zero instruction/data) into it while stalled.
- Non-memory instructions pass through with zero added latency.

Parameters:
- ADDR_W, 12, data-memory word address width; dmem_addr = aluin[ADDR_W-1:0].
- TIMEOUT_CYC, 255, max cycles in REQ without ack before abort; legal range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instructionin  in  32  instruction from X/M latch; opcode = [31:27].
- aluin  in  32  ALU result (effective address for lw/sw).
- datain  in  32  store data (rd value) for sw.
- PCin  in  32  PC+1 of instruction.
- aluout  out  32  to M/W latch.
- dmemout  out  32  load data to M/W latch.
- instructionout  out  32  to M/W latch.
- PCout  out  32  to M/W latch.
- stall  out  1  high = X/M latch and earlier stages must hold.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = write (sw), registered.
- dmem_addr  out  ADDR_W  word address, registered.
- dmem_wdata  out  32  store data, registered.
- dmem_ack  in  1  one-cycle completion pulse; sampled only while dmem_req=1.
- dmem_rdata  in  32  load data, valid in the ack cycle.
- mem_err  out  1  sticky timeout flag, registered.

Behaviour:
- Decode:
  - lw = opcode 5'b01000; sw = 5'b00111; all others are non-memory.
- States and transitions:
  - IDLE:
    - Non-memory instruction: stall=0. Outputs pass inputs combinationally; dmemout=0.
    - Memory op: stall=1, outputs are the bubble (all 0). Next cycle: REQ, with dmem_req=1, dmem_we=(sw), dmem_addr and dmem_wdata loaded from the inputs, timeout counter cleared.
  - REQ:
    - stall=1, bubble out. req/we/addr/wdata held stable.
    - On dmem_ack=1: capture dmem_rdata into rdata_q (0 for sw), drop req, go RESP.
    - Else, when the counter reaches TIMEOUT_CYC-1: drop req, set mem_err, rdata_q=0, go RESP.
    - Otherwise increment the counter.
  - RESP:
    - stall=0. Outputs are the held input op, with dmemout=rdata_q for lw and 0 for sw.
    - Next state: IDLE. Upstream advances at this edge.
- Latency and timing:
  - Memory op occupies the stage for 2+N cycles, where N = cycles in REQ (N>=1; ack earliest in the first REQ cycle).
  - Inputs are guaranteed stable while stall=1.
  - A memory op arriving in IDLE right after RESP starts a new access normally. There is no back-to-back shortcut.
- Ack handling:
  - Ack outside REQ is ignored.
  - Ack in the same cycle as the timeout compare: ack wins, mem_err not set.
- mem_err:
  - Sticky until rst.
  - Does not block later accesses.
- Reset:
  - While rst=1, all outputs are 0 and stall=0.
  - Next edge: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, rdata_q=0, counter=0, mem_err=0.
  - Reset in REQ abandons the access: req low from the next cycle, no response emitted.

Optional Feature:
- Macro MEM_STAGE_PERF_CNT_EN.
- Defined: adds output stall_cycles [31:0] and output mem_ops [31:0].
  - stall_cycles increments each cycle stall=1.
  - mem_ops increments on each RESP cycle.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. rst=1 for 2 cycles with random inputs -> all outputs 0, stall=0; after release dmem_req=0, mem_err=0.
2. IDLE, instructionin=32'h00C52820 (add), aluin=5, PCin=9 -> same cycle aluout=5, PCout=9, instructionout=32'h00C52820, dmemout=0, stall=0, dmem_req=0.
3. lw (opcode 01000), aluin=32'h10, ack returned on 2nd REQ cycle with rdata=32'hDEADBEEF:
   - c0: stall=1, bubble.
   - c1–c2: dmem_req=1, addr=12'h010, we=0.
   - c3: stall=0, dmemout=32'hDEADBEEF, aluout=32'h10.
4. sw (opcode 00111), datain=32'h1234, ack in first REQ cycle -> dmem_we=1, dmem_wdata=32'h1234 for 1 cycle; RESP dmemout=0; total 3 cycles of stage occupancy.
5. TIMEOUT_CYC=4, lw, no ack -> dmem_req high exactly 4 cycles; then RESP with dmemout=0, mem_err=1, and mem_err stays 1 through a following successful lw.
6. rst asserted in the 2nd REQ cycle of a lw -> dmem_req=0 next cycle, state IDLE, mem_err=0, no RESP output; a late ack afterwards is ignored.
